multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle MIPS control unit: replaces the single-cycle opcode/funct decoder with a Moore FSM that
//  sequences FETCH/DECODE/EXECUTE/MEM/WB over several cycles and drives datapath enables/muxes per state.
//  Sits in cpu/ between instruction register and shared-memory datapath; adds memory wait-state
//  handshake, optional immediate-logic/BNE extension and illegal-instruction trap.
// PARAMETERS
//  EXT_EN          0  1: also decode ANDI(001100), ORI(001101), BNE(000101); 0: these are illegal
//  TRAP_ON_ILLEGAL 1  1: illegal op/funct -> TRAP (sticky); 0: illegal treated as NOP (back to FETCH)
//  ALUCTL_W        3  width of alu_ctl
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  rst_n      in   1  synchronous active-low reset
//  op         in   6  instr[31:26] from instruction register
//  funct      in   6  instr[5:0] from instruction register
//  zero       in   1  ALU zero flag (valid in BRANCH state)
//  mem_ready  in   1  memory completes access this cycle
//  iord       out  1  0: address=PC, 1: address=ALUOut
//  mem_write  out  1  memory write strobe
//  ir_write   out  1  load instruction register
//  reg_dst    out  1  0: rt, 1: rd
//  mem_to_reg out  1  0: ALUOut, 1: Data
//  reg_write  out  1  register file write
//  alu_src_a  out  1  0: PC, 1: rs
//  alu_src_b  out  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2 (ANDI/ORI use zero-ext via imm_zx)
//  imm_zx     out  1  1: immediate zero-extended (ANDI/ORI only)
//  pc_src     out  2  00 ALUResult, 01 ALUOut, 10 jump target
//  alu_ctl    out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
//  pc_en      out  1  pc_write | (branch & (zero ^ bne))
//  illegal    out  1  sticky illegal-instruction flag
//  state_o    out  4  current state encoding (debug)
// BEHAVIOUR
//  - Moore outputs from registered state; pc_en additionally combinational on zero. No output registers.
//  - rst_n=0 at edge: state<=FETCH, illegal<=0. While rst_n=0 all write strobes (mem_write, ir_write,
//    reg_write, pc_en) forced 0; muxes/alu_ctl hold FETCH values (iord=0,alu_src_a=0,alu_src_b=01,add,pc_src=00).
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP, TRAP.
//  - FETCH: iord=0, alu PC+4; ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready=1, then DECODE.
//  - DECODE: alu PC+(imm<<2) (branch target precompute). Next: LW/SW->MEMADR, RTYPE->EXEC,
//    BEQ/BNE->BRANCH, ADDI/ANDI/ORI->IMMEX, J->JUMP, illegal->TRAP or FETCH per TRAP_ON_ILLEGAL.
//  - RTYPE legal functs: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010; any other = illegal,
//    checked in DECODE (funct decoded from funct port, never from op).
//  - MEMADR: rs+signimm, add -> MEMRD (LW) / MEMWR (SW).
//  - MEMRD: iord=1; waits on mem_ready, then MEMWB. MEMWB: reg_write, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - MEMWR: iord=1, mem_write=1 every cycle until mem_ready=1 (write occurs that cycle) -> FETCH.
//  - EXEC: rs op rt per funct -> ALUWB (reg_dst=1, reg_write) -> FETCH.
//  - IMMEX: rs op imm (ADDI add/signext, ANDI and, ORI or, imm_zx=1) -> IMMWB (reg_dst=0, reg_write) -> FETCH.
//  - BRANCH: sub, pc_src=01, branch=1; BEQ takes on zero=1, BNE on zero=0 -> FETCH.
//  - JUMP: pc_src=10, pc_write=1 -> FETCH.
//  - TRAP: all strobes 0, illegal=1, absorbing until rst_n=0.
//  - Latency (cycles, zero wait): LW 5, SW 4, R/IMM 4, BEQ/BNE 3, J 3; each mem_ready=0 cycle adds 1.
//  - Reset mid-instruction: next cycle FETCH, no partial write completes after reset edge.
//  - Unreachable state encodings recover to FETCH.
// STRUCTURE
//  - lib_cpu package: OPECODE/FUNCT enums (add ANDI, ORI, BNE), STATE enum (4-bit), ALUCTL_* constants.
//  - Sub-module alu_decoder: (aluop[1:0], funct) -> alu_ctl, funct_legal; purely combinational.
//  - FSM next-state and output decode in this module; one always_ff for state/illegal.
// TESTING
//  - Reset then ADD ($op=0,funct=100000), mem_ready=1 -> FETCH,DECODE,EXEC,ALUWB; reg_write=1 only in ALUWB.
//  - LW with mem_ready low 2 cycles in FETCH and 3 in MEMRD -> 10 cycles, ir_write once, reg_write once.
//  - SW, mem_ready low 1 cycle in MEMWR -> mem_write high 2 cycles, iord=1 both, then FETCH.
//  - BEQ zero=1 -> pc_en=1 in BRANCH; zero=0 -> pc_en=0; EXT_EN=1 BNE inverts both.
//  - op=001101 with EXT_EN=0, TRAP_ON_ILLEGAL=1 -> TRAP, illegal=1 held; rst_n=0 -> FETCH, illegal=0.
//  - funct=000000 RTYPE, TRAP_ON_ILLEGAL=0 -> DECODE->FETCH, no reg_write, illegal stays 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - opcode_e / funct_e : instruction fields the controller decodes
//   - state_e            : 4-bit FSM state encoding, also visible on state_o
//   - ALUCTL_* / ALUOP_* : ALU control codes and the FSM-to-decoder ALU request
package multicycle_control_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010
  } funct_e;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: turns the FSM's ALU request and the R-type funct field into
// an ALU control code, and flags whether funct names a supported operation.
//   aluop       in  2  00 add, 01 sub, 10 per funct, 11 add
//   funct       in  6  instr[5:0]
//   alu_ctl     out 3  ALU control code
//   funct_legal out 1  funct is one of ADD/SUB/AND/OR/SLT (independent of aluop)
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       funct_legal
);

  logic [2:0] fn_ctl;

  always_comb begin
    fn_ctl      = ALUCTL_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  fn_ctl = ALUCTL_ADD;
      FN_SUB:  fn_ctl = ALUCTL_SUB;
      FN_AND:  fn_ctl = ALUCTL_AND;
      FN_OR:   fn_ctl = ALUCTL_OR;
      FN_SLT:  fn_ctl = ALUCTL_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctl = ALUCTL_ADD;
    case (aluop)
      ALUOP_SUB:   alu_ctl = ALUCTL_SUB;
      ALUOP_FUNCT: alu_ctl = fn_ctl;
      default:     alu_ctl = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit. A Moore FSM sequences each instruction
// through FETCH/DECODE/execute/memory/writeback states and drives the shared
// datapath's enables and mux selects from the registered state.
// Inputs : clk, rst_n (sync, active low), op, funct, zero, mem_ready
// Outputs: iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//          alu_src_a, alu_src_b, imm_zx, pc_src, alu_ctl, pc_en,
//          illegal (sticky trap flag), state_o (debug state)
// Memory handshake: mem_ready=1 in FETCH/MEMRD/MEMWR means the access
// completes in that cycle; otherwise the FSM holds the state and its strobes.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit EXT_EN          = 1'b0,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int ALUCTL_W        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                imm_zx,
  output logic [1:0]          pc_src,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                pc_en,
  output logic                illegal,
  output logic [3:0]          state_o
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  state_e     ill_next;

  logic [1:0] aluop;
  logic [2:0] dec_ctl;
  logic       funct_legal;
  logic       imm_logic;
  logic [2:0] imm_ctl;
  logic       pc_write;
  logic       branch;
  logic       is_bne;

  multicycle_control_alu_decoder u_alu_dec (
    .aluop       (aluop),
    .funct       (funct),
    .alu_ctl     (dec_ctl),
    .funct_legal (funct_legal)
  );

  assign ill_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
  assign is_bne   = EXT_EN && (op == OP_BNE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = funct_legal ? S_EXEC : ill_next;
          OP_BEQ:           state_d = S_BRANCH;
          OP_BNE:           state_d = EXT_EN ? S_BRANCH : ill_next;
          OP_ADDI:          state_d = S_IMMEX;
          OP_ANDI, OP_ORI:  state_d = EXT_EN ? S_IMMEX : ill_next;
          OP_J:             state_d = S_JUMP;
          default:          state_d = ill_next;
        endcase
      end
      // op is held in the instruction register, so it still selects LW vs SW here
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Output decode. Defaults are the FETCH mux settings with every strobe
  // low; holding rst_n low keeps them there regardless of the current state.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b01;
    imm_zx     = 1'b0;
    pc_src     = 2'b00;
    aluop      = ALUOP_ADD;
    imm_logic  = 1'b0;
    imm_ctl    = ALUCTL_ADD;
    pc_write   = 1'b0;
    branch     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD:  iord = 1'b1;
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b00;
          aluop     = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b00;
          aluop     = ALUOP_SUB;
          pc_src    = 2'b01;
          branch    = 1'b1;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          // ANDI/ORI bypass the funct decoder: their ALU op comes from the opcode
          if (EXT_EN && (op == OP_ANDI || op == OP_ORI)) begin
            imm_zx    = 1'b1;
            imm_logic = 1'b1;
            imm_ctl   = (op == OP_ANDI) ? ALUCTL_AND : ALUCTL_OR;
          end
        end
        S_IMMWB:  reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Branch decision is resolved combinationally from the live zero flag.
  assign pc_en   = pc_write | (branch & (zero ^ is_bne));
  assign alu_ctl = ALUCTL_W'(imm_logic ? imm_ctl : dec_ctl);
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Two instances share clk/rst_n/op/funct/zero:
// u_dut0 is the base configuration (no extension, traps on illegal) and
// u_dut1 enables ANDI/ORI/BNE and treats illegal instructions as NOPs.
// Each has its own mem_ready; the idle one keeps mem_ready low so it waits in
// FETCH (or TRAP). Expected per-cycle outputs come from an instruction-level
// model: the instruction class picks the list of phases it walks through.
module tb_multicycle_control;

  localparam logic [3:0] ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3,  ST_MEMWB  = 4'd4,  ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6,  ST_ALUWB  = 4'd7,  ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_IMMEX  = 4'd9,  ST_IMMWB  = 4'd10, ST_JUMP   = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd12;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_IMM = 3, K_BR = 4, K_J = 5, K_ILL = 6;

  typedef struct packed {
    logic [3:0] st;
    logic       iord;
    logic       mw;
    logic       irw;
    logic       rd;
    logic       m2r;
    logic       rw;
    logic       a;
    logic [1:0] b;
    logic       zx;
    logic [1:0] pcs;
    logic [2:0] ctl;
    logic       pcen;
    logic       ill;
  } ov_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mr [2];

  logic       iord_w [2], memw_w [2], irw_w [2], rd_w [2], m2r_w [2], rw_w [2];
  logic       a_w [2], zx_w [2], pcen_w [2], ill_w [2];
  logic [1:0] b_w [2], pcs_w [2];
  logic [2:0] ctl_w [2];
  logic [3:0] st_w [2];
  ov_t        ob [2];

  int n_cmp;
  int n_fail;

  multicycle_control #(.EXT_EN(1'b0), .TRAP_ON_ILLEGAL(1'b1), .ALUCTL_W(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mr[0]),
    .iord(iord_w[0]), .mem_write(memw_w[0]), .ir_write(irw_w[0]), .reg_dst(rd_w[0]),
    .mem_to_reg(m2r_w[0]), .reg_write(rw_w[0]), .alu_src_a(a_w[0]), .alu_src_b(b_w[0]),
    .imm_zx(zx_w[0]), .pc_src(pcs_w[0]), .alu_ctl(ctl_w[0]), .pc_en(pcen_w[0]),
    .illegal(ill_w[0]), .state_o(st_w[0])
  );

  multicycle_control #(.EXT_EN(1'b1), .TRAP_ON_ILLEGAL(1'b0), .ALUCTL_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mr[1]),
    .iord(iord_w[1]), .mem_write(memw_w[1]), .ir_write(irw_w[1]), .reg_dst(rd_w[1]),
    .mem_to_reg(m2r_w[1]), .reg_write(rw_w[1]), .alu_src_a(a_w[1]), .alu_src_b(b_w[1]),
    .imm_zx(zx_w[1]), .pc_src(pcs_w[1]), .alu_ctl(ctl_w[1]), .pc_en(pcen_w[1]),
    .illegal(ill_w[1]), .state_o(st_w[1])
  );

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ob[i] = {st_w[i], iord_w[i], memw_w[i], irw_w[i], rd_w[i], m2r_w[i], rw_w[i],
               a_w[i], b_w[i], zx_w[i], pcs_w[i], ctl_w[i], pcen_w[i], ill_w[i]};
    end
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FETCH mux settings, all strobes low, in the given state
  function automatic ov_t base(input logic [3:0] st);
    ov_t e;
    e      = '0;
    e.st   = st;
    e.b    = 2'b01;
    e.ctl  = 3'b010;
    return e;
  endfunction

  function automatic int classify(input logic [5:0] o, input logic [5:0] f, input bit ext);
    case (o)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) ? K_R : K_ILL;
      6'b000100: return K_BR;
      6'b000101: return ext ? K_BR : K_ILL;
      6'b001000: return K_IMM;
      6'b001100, 6'b001101: return ext ? K_IMM : K_ILL;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] ctl_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle on dut d: drive mem_ready, compare at negedge, step past the edge.
  task automatic cyc(input int d, input logic mrv, input ov_t e, input string tag);
    mr[d] = mrv;
    @(negedge clk);
    n_cmp++;
    assert (ob[d] === e) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, ob[d], e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_dec(input int d, input int fw);
    ov_t e;
    e = base(ST_FETCH);
    for (int i = 0; i < fw; i++) cyc(d, 1'b0, e, "fetch_wait");
    e.irw = 1'b1; e.pcen = 1'b1;
    cyc(d, 1'b1, e, "fetch");
    e = base(ST_DECODE); e.b = 2'b11;
    cyc(d, rbit(), e, "decode");
  endtask

  // Hold reset for one edge with mem_ready high; outputs must show st with all
  // strobes low, then the unit must be back in FETCH with illegal clear.
  task automatic reset_chk(input int d, input logic [3:0] st, input logic ill);
    ov_t e;
    rst_n = 1'b0;
    e = base(st); e.ill = ill;
    cyc(d, 1'b1, e, "in_reset");
    rst_n = 1'b1;
    mr[d] = 1'b0;
    cyc(d, 1'b0, base(ST_FETCH), "after_reset");
  endtask

  task automatic do_instr(input int d, input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int fw, input int mw, output bit trapped);
    ov_t e;
    int  k;
    k       = classify(o, f, d == 1);
    trapped = 1'b0;
    op = o; funct = f; zero = z;
    fetch_dec(d, fw);
    case (k)
      K_LW, K_SW: begin
        e = base(ST_MEMADR); e.a = 1'b1; e.b = 2'b10;
        cyc(d, rbit(), e, "memadr");
        e = base(k == K_LW ? ST_MEMRD : ST_MEMWR); e.iord = 1'b1; e.mw = (k == K_SW);
        for (int i = 0; i < mw; i++) cyc(d, 1'b0, e, "mem_wait");
        cyc(d, 1'b1, e, "mem_done");
        if (k == K_LW) begin
          e = base(ST_MEMWB); e.rw = 1'b1; e.m2r = 1'b1;
          cyc(d, rbit(), e, "memwb");
        end
      end
      K_R: begin
        e = base(ST_EXEC); e.a = 1'b1; e.b = 2'b00; e.ctl = ctl_of(f);
        cyc(d, rbit(), e, "exec");
        e = base(ST_ALUWB); e.rd = 1'b1; e.rw = 1'b1;
        cyc(d, rbit(), e, "aluwb");
      end
      K_IMM: begin
        e = base(ST_IMMEX); e.a = 1'b1; e.b = 2'b10;
        if (o == 6'b001100) begin e.ctl = 3'b000; e.zx = 1'b1; end
        if (o == 6'b001101) begin e.ctl = 3'b001; e.zx = 1'b1; end
        cyc(d, rbit(), e, "immex");
        e = base(ST_IMMWB); e.rw = 1'b1;
        cyc(d, rbit(), e, "immwb");
      end
      K_BR: begin
        e = base(ST_BRANCH); e.a = 1'b1; e.b = 2'b00; e.ctl = 3'b110; e.pcs = 2'b01;
        e.pcen = (o == 6'b000101) ? ~z : z;
        cyc(d, rbit(), e, "branch");
      end
      K_J: begin
        e = base(ST_JUMP); e.pcs = 2'b10; e.pcen = 1'b1;
        cyc(d, rbit(), e, "jump");
      end
      default: begin
        if (d == 0) begin
          e = base(ST_TRAP); e.ill = 1'b1;
          for (int i = 0; i < 3; i++) cyc(d, rbit(), e, "trap_hold");
          trapped = 1'b1;
        end
      end
    endcase
    mr[d] = 1'b0;
  endtask

  logic [5:0] op_tab [10];
  logic [5:0] fn_tab [5];

  initial begin
    bit  t;
    ov_t e;
    int  d;
    logic [5:0] o, f;
    n_cmp = 0; n_fail = 0;
    op_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
               6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b111111};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst_n = 1'b0; mr[0] = 1'b0; mr[1] = 1'b0;
    op = '0; funct = '0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state of both instances
    cyc(0, 1'b0, base(ST_FETCH), "reset0");
    cyc(1, 1'b0, base(ST_FETCH), "reset1");

    // ADD with zero wait states
    do_instr(0, 6'b000000, 6'b100000, 1'b0, 0, 0, t);
    // LW: 2 waits in FETCH, 3 in MEMRD
    do_instr(0, 6'b100011, 6'b000000, 1'b0, 2, 3, t);
    // SW: 1 wait in MEMWR
    do_instr(0, 6'b101011, 6'b000000, 1'b0, 0, 1, t);
    // BEQ taken / not taken, BNE both ways with the extension
    do_instr(0, 6'b000100, 6'b000000, 1'b1, 0, 0, t);
    do_instr(0, 6'b000100, 6'b000000, 1'b0, 0, 0, t);
    do_instr(1, 6'b000101, 6'b000000, 1'b1, 0, 0, t);
    do_instr(1, 6'b000101, 6'b000000, 1'b0, 0, 0, t);
    // extension ops, ADDI, J, SLT
    do_instr(1, 6'b001100, 6'b000000, 1'b0, 1, 0, t);
    do_instr(1, 6'b001101, 6'b000000, 1'b0, 0, 0, t);
    do_instr(0, 6'b001000, 6'b000000, 1'b0, 0, 0, t);
    do_instr(1, 6'b000010, 6'b000000, 1'b0, 0, 0, t);
    do_instr(1, 6'b000000, 6'b101010, 1'b0, 0, 0, t);
    // ORI without extension traps; reset clears it
    do_instr(0, 6'b001101, 6'b000000, 1'b0, 0, 0, t);
    if (t) reset_chk(0, ST_TRAP, 1'b1);
    // illegal funct treated as NOP when trapping is off
    do_instr(1, 6'b000000, 6'b000000, 1'b0, 0, 0, t);
    cyc(1, 1'b0, base(ST_FETCH), "nop_back_to_fetch");
    // reset in the middle of a store: no write strobe while reset is held
    op = 6'b101011; funct = '0;
    fetch_dec(0, 0);
    e = base(ST_MEMADR); e.a = 1'b1; e.b = 2'b10;
    cyc(0, 1'b0, e, "memadr");
    reset_chk(0, ST_MEMWR, 1'b0);
    // reset during register writeback
    op = 6'b000000; funct = 6'b100000;
    fetch_dec(1, 0);
    e = base(ST_EXEC); e.a = 1'b1; e.b = 2'b00;
    cyc(1, 1'b0, e, "exec");
    reset_chk(1, ST_ALUWB, 1'b0);

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      o = op_tab[$urandom_range(0, 9)];
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      do_instr(d, o, f, rbit(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), t);
      if (t) reset_chk(d, ST_TRAP, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
